// File: rtl/bcd_converter.sv
// bcd_converter: sequential double-dabble conversion of a signed 16-bit value
// into a sign flag plus five BCD digits of its magnitude, one bit per clock.
module bcd_converter (
  input  logic        clk,
  input  logic        R,
  input  logic        start,
  input  logic [15:0] P,
  output logic [3:0]  D0,
  output logic [3:0]  D1,
  output logic [3:0]  D2,
  output logic [3:0]  D3,
  output logic [3:0]  D4,
  output logic        neg,
  output logic        busy,
  output logic        done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [15:0] mag;
  logic        sign;
  logic [19:0] scratch, adj, shifted;
  logic [3:0]  cnt;
  logic        last;
  genvar i;
  for (i = 0; i < 5; i++) begin : g_adj
    assign adj[4*i +: 4] = scratch[4*i +: 4] >= 4'd5 ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
  end
  assign shifted = {adj[18:0], mag[15]};
  assign last    = cnt == 4'd15;
  assign busy    = state == SHIFT;
  always_ff @(posedge clk or posedge R)
    if (R) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  end
  always_ff @(posedge clk or posedge R)
    if (R) begin
      mag     <= '0;
      sign    <= 1'b0;
      scratch <= '0;
      cnt     <= '0;
      {D4, D3, D2, D1, D0} <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        // 0x8000 negates to itself, which read unsigned is exactly 32768
        mag     <= P[15] ? ~P + 16'd1 : P;
        sign    <= P[15];
        scratch <= '0;
        cnt     <= '0;
      end else if (state == SHIFT) begin
        scratch <= shifted;
        mag     <= {mag[14:0], 1'b0};
        cnt     <= cnt + 4'd1;
        if (last) begin
          {D4, D3, D2, D1, D0} <= shifted;
          neg  <= sign;
          done <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_bcd_converter.sv
// tb_bcd_converter: scoreboard bench; stimulus pushes decimal-model expectations,
// a negedge monitor pops and compares them whenever done is seen.
module tb_bcd_converter;
  logic        clk = 1'b0, R = 1'b1, start = 1'b0;
  logic [15:0] P = '0;
  logic [3:0]  D0, D1, D2, D3, D4;
  logic        neg, busy, done;
  int          checks = 0, fails = 0, cyc = 0;
  typedef struct {logic [19:0] dig; logic n; int acc; int done_cyc; logic [15:0] p;} exp_t;
  exp_t        q[$];
  logic [20:0] held = '0;
  bcd_converter dut (.clk(clk), .R(R), .start(start), .P(P), .D0(D0), .D1(D1), .D2(D2),
                     .D3(D3), .D4(D4), .neg(neg), .busy(busy), .done(done));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  // decimal reference: magnitude by integer arithmetic, digits by divide/modulo
  task automatic push(input logic [15:0] p, input int c);
    exp_t e;
    int a, d;
    a = p[15] ? 65536 - int'(p) : int'(p);
    d = 1;
    for (int k = 0; k < 5; k++) begin
      e.dig[4*k +: 4] = 4'((a / d) % 10);
      d = d * 10;
    end
    e.n = p[15];
    e.acc = c + 1;
    e.done_cyc = c + 17;
    e.p = p;
    q.push_back(e);
  endtask
  task automatic issue(input logic [15:0] p);
    @(posedge clk); #1;
    start = 1'b1;
    P = p;
    push(p, cyc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while (q.size() > 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL done_timeout: %0d conversions pending, required 0", q.size());
      q.delete();
    end
  endtask
  always @(negedge clk) begin
    if (R) begin
      chk("reset_outputs", {D4, D3, D2, D1, D0, neg, busy, done}, 32'h0);
      held = '0;
    end else begin
      chk("busy", busy, q.size() > 0 && cyc >= q[0].acc && cyc < q[0].done_cyc);
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL spurious_done: done high with no conversion pending");
        end else begin
          chk("digits", {D4, D3, D2, D1, D0}, q[0].dig);
          chk("neg", neg, q[0].n);
          chk("latency", cyc, q[0].done_cyc);
          void'(q.pop_front());
        end
        held = {D4, D3, D2, D1, D0, neg};
      end else
        chk("hold", {D4, D3, D2, D1, D0, neg}, held);
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 R = 1'b0;
    issue(16'h0000);
    wait_idle();
    issue(16'h3039);
    wait_idle();
    issue(16'hFFFF);
    wait_idle();
    issue(16'h8000);
    wait_idle();
    issue(16'h7FFF);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    P = 16'h0001;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    issue(16'h3039);
    repeat (7) @(posedge clk);
    #1 R = 1'b1;
    q.delete();
    #1 chk("async_reset", {D4, D3, D2, D1, D0, neg, busy, done}, 32'h0);
    repeat (2) @(posedge clk);
    #1 R = 1'b0;
    repeat (20) @(posedge clk);
    issue(16'hFF85);
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1;
    P = 16'h0064;
    push(P, cyc);
    repeat (17) @(posedge clk);
    #1 P = 16'hFF9C;
    push(P, cyc);
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(16'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 13)) @(posedge clk);
        #1 start = 1'b1;
        P = 16'($urandom);
        @(posedge clk); #1 start = 1'b0;
      end
      wait_idle();
    end
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
